// File: rtl/module_top_enco_gray_pkg.sv
// Shared widths, segment patterns and helpers for the binary-to-Gray encoder board design.
// Used by both builds; the optional auto-count feature is controlled by GRAY_AUTO_COUNT_EN.
package pkg_enco_gray;

    localparam int DATA_W = 4;
    localparam int SEG_W  = 7;
    localparam int DIG_N  = 2;

    // Segment patterns {g,f,e,d,c,b,a}, active-low (0 = segment lit)
    localparam logic [SEG_W-1:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [DIG_N-1:0] ANODE_OFF = 2'b11;

    function automatic logic [DATA_W-1:0] bin2gray(input logic [DATA_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [SEG_W-1:0] segOf(input logic [DATA_W-1:0] digit);
        case (digit)
            4'd0:    return SEG_LUT[0];
            4'd1:    return SEG_LUT[1];
            4'd2:    return SEG_LUT[2];
            4'd3:    return SEG_LUT[3];
            4'd4:    return SEG_LUT[4];
            4'd5:    return SEG_LUT[5];
            4'd6:    return SEG_LUT[6];
            4'd7:    return SEG_LUT[7];
            4'd8:    return SEG_LUT[8];
            4'd9:    return SEG_LUT[9];
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/module_top_enco_gray_seg_scan.sv
// Two-digit multiplexed 7-segment scanner: alternates units/tens slots every
// DISPLAY_REFRESH cycles, blanking a leading zero in the tens slot.
module module_seg_scan_enco
    import pkg_enco_gray::*;
#(
    parameter int DISPLAY_REFRESH = 27000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tens_i,
    input  logic [DATA_W-1:0] units_i,
    output logic [DIG_N-1:0]  anode_o,
    output logic [SEG_W-1:0]  cathode_o
);

    localparam int DSP_W = $clog2(DISPLAY_REFRESH);
    localparam logic [DSP_W-1:0] DSP_LAST = DSP_W'(DISPLAY_REFRESH - 1);

    localparam logic SEL_UNITS = 1'b0;
    localparam logic SEL_TENS  = 1'b1;

    logic [DSP_W-1:0] r_dspCnt;
    logic             r_sel;
    logic             w_wrap;

    assign w_wrap = (r_dspCnt == DSP_LAST);

    // r_sel names the slot shown at the next wrap, so the first slot after reset is units
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dspCnt  <= '0;
            r_sel     <= SEL_UNITS;
            anode_o   <= ANODE_OFF;
            cathode_o <= SEG_BLANK;
        end else if (w_wrap) begin
            r_dspCnt <= '0;
            r_sel    <= ~r_sel;
            if (r_sel == SEL_UNITS) begin
                anode_o   <= 2'b10;
                cathode_o <= segOf(units_i);
            end else begin
                anode_o   <= 2'b01;
                cathode_o <= tens_i ? SEG_LUT[1] : SEG_BLANK;
            end
        end else begin
            r_dspCnt <= r_dspCnt + 1'b1;
        end
    end

endmodule

// File: rtl/module_top_enco_gray.sv
// Binary-to-Gray encoder top: samples the switches at a slow refresh, drives Gray code on
// active-low LEDs and the decimal value on the scanned display. Option: GRAY_AUTO_COUNT_EN.
module module_top_enco_gray
    import pkg_enco_gray::*;
#(
    parameter int INPUT_REFRESH   = 2700000,
    parameter int DISPLAY_REFRESH = 27000
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
`ifdef GRAY_AUTO_COUNT_EN
    input  logic              auto_pi,
`endif
    input  logic [DATA_W-1:0] bin_code_pi,
    output logic [DATA_W-1:0] led_gray_code_po,
    output logic [DIG_N-1:0]  anode_po,
    output logic [SEG_W-1:0]  cathode_po
);

    localparam int IN_W = $clog2(INPUT_REFRESH);
    localparam logic [IN_W-1:0] IN_LAST = IN_W'(INPUT_REFRESH - 1);

    logic [DATA_W-1:0] r_binS1;
    logic [DATA_W-1:0] r_binS2;
    logic [IN_W-1:0]   r_inCnt;
    logic [DATA_W-1:0] r_binQ;
    logic [DATA_W-1:0] r_grayQ;
    logic              w_inTick;
    logic              w_tens;
    logic [DATA_W-1:0] w_units;

    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_binS1 <= '0;
            r_binS2 <= '0;
        end else begin
            r_binS1 <= bin_code_pi;
            r_binS2 <= r_binS1;
        end
    end

`ifdef GRAY_AUTO_COUNT_EN
    logic r_autoS1;
    logic r_autoS2;

    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_autoS1 <= 1'b0;
            r_autoS2 <= 1'b0;
        end else begin
            r_autoS1 <= auto_pi;
            r_autoS2 <= r_autoS1;
        end
    end
`endif

    assign w_inTick = (r_inCnt == IN_LAST);

    // Sampling only at the tick is what debounces the switches
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_inCnt <= '0;
            r_binQ  <= '0;
            r_grayQ <= '0;
        end else begin
            r_inCnt <= w_inTick ? '0 : r_inCnt + 1'b1;
            if (w_inTick) begin
`ifdef GRAY_AUTO_COUNT_EN
                r_binQ <= r_autoS2 ? r_binQ + 1'b1 : r_binS2;
`else
                r_binQ <= r_binS2;
`endif
            end
            r_grayQ <= bin2gray(r_binQ);
        end
    end

    assign led_gray_code_po = ~r_grayQ;

    assign w_tens  = (r_binQ >= 4'd10);
    assign w_units = w_tens ? r_binQ - 4'd10 : r_binQ;

    module_seg_scan_enco #(
        .DISPLAY_REFRESH (DISPLAY_REFRESH)
    ) u_segScan (
        .clk_i     (clk_pi),
        .rst_i     (rst_pi),
        .tens_i    (w_tens),
        .units_i   (w_units),
        .anode_o   (anode_po),
        .cathode_o (cathode_po)
    );

endmodule

// File: tb/tb_module_top_enco_gray.sv
// Self-checking bench for module_top_enco_gray using a scoreboard queue of expectations.
// Covers the GRAY_AUTO_COUNT_EN auto-count mode when that macro is defined.
module tb_module_top_enco_gray;

    logic       clk;
    logic       rst;
    logic [3:0] binCode;
    logic       autoPi;
    logic [3:0] led;
    logic [1:0] anode;
    logic [6:0] cathode;

    int cmpCount = 0;
    int errCount = 0;
    int cycCnt   = 0;

    typedef struct {
        int         kind;
        logic [6:0] val;
    } exp_t;

    localparam int KIND_LED   = 0;
    localparam int KIND_UNITS = 1;
    localparam int KIND_TENS  = 2;

    exp_t expQ[$];

    logic [6:0] segTable [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    module_top_enco_gray #(
        .INPUT_REFRESH   (4),
        .DISPLAY_REFRESH (3)
    ) dut (
        .clk_pi           (clk),
        .rst_pi           (rst),
`ifdef GRAY_AUTO_COUNT_EN
        .auto_pi          (autoPi),
`endif
        .bin_code_pi      (binCode),
        .led_gray_code_po (led),
        .anode_po         (anode),
        .cathode_po       (cathode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter since reset release, used to place stimulus relative to the sample tick
    always @(posedge clk) begin
        if (rst) cycCnt <= 0;
        else     cycCnt <= cycCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        cmpCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int kind, input logic [6:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input string tag, input int kind, input logic [6:0] observed);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queued"}, 16'(expQ.size()), 16'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_kind"}, 16'(e.kind), 16'(kind));
            checkOutput(tag, {9'd0, observed}, {9'd0, e.val});
        end
    endtask

    // Drive a switch value and queue what the LEDs (and optionally the display) must show
    task automatic applyStimulus(input logic [3:0] value, input bit withDisplay);
        logic [3:0] gray;
        logic [3:0] unitsDigit;
        logic       isTens;
        binCode = value;
        gray = value ^ {1'b0, value[3:1]};
        pushExp(KIND_LED, {3'd0, ~gray});
        if (withDisplay) begin
            isTens     = (value >= 4'd10);
            unitsDigit = isTens ? value - 4'd10 : value;
            pushExp(KIND_UNITS, segTable[unitsDigit]);
            pushExp(KIND_TENS, isTens ? segTable[1] : 7'h7F);
        end
    endtask

    task automatic captureDisplay(input string tag);
        logic [6:0] unitsSeen;
        logic [6:0] tensSeen;
        bit         gotUnits;
        bit         gotTens;
        gotUnits  = 0;
        gotTens   = 0;
        unitsSeen = '0;
        tensSeen  = '0;
        waitCycles(4);
        for (int i = 0; i < 6; i++) begin
            if (anode == 2'b10) begin
                unitsSeen = cathode;
                gotUnits  = 1;
            end
            if (anode == 2'b01) begin
                tensSeen = cathode;
                gotTens  = 1;
            end
            waitCycles(1);
        end
        checkOutput({tag, "_unitsSlotSeen"}, 16'(gotUnits), 16'd1);
        checkOutput({tag, "_tensSlotSeen"}, 16'(gotTens), 16'd1);
        popCheck({tag, "_units"}, KIND_UNITS, unitsSeen);
        popCheck({tag, "_tens"}, KIND_TENS, tensSeen);
    endtask

    task automatic alignPhase(input int phase);
        for (int i = 0; i < 4; i++) begin
            if ((cycCnt % 4) != phase) waitCycles(1);
        end
        checkOutput("alignPhase", 16'(cycCnt % 4), 16'(phase));
    endtask

    initial begin
        logic [3:0] prevLed;
        rst     = 1'b1;
        binCode = 4'd0;
        autoPi  = 1'b0;

        // Reset held three cycles, outputs dark
        waitCycles(3);
        checkOutput("reset_led", {12'd0, led}, 16'hF);
        checkOutput("reset_anode", {14'd0, anode}, 16'h3);
        checkOutput("reset_cathode", {9'd0, cathode}, 16'h7F);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("rel1_anode", {14'd0, anode}, 16'h3);
        waitCycles(1);
        checkOutput("rel2_anode", {14'd0, anode}, 16'h3);
        waitCycles(1);
        checkOutput("rel3_anode", {14'd0, anode}, 16'h2);
        checkOutput("rel3_cathode", {9'd0, cathode}, 16'h40);

        // Value 5: gray 0111, units 5, tens blank
        applyStimulus(4'd5, 1);
        waitCycles(8);
        popCheck("v5_led", KIND_LED, {3'd0, led});
        captureDisplay("v5");

        // Value 13: gray 1011, tens 1, units 3
        applyStimulus(4'd13, 1);
        waitCycles(8);
        popCheck("v13_led", KIND_LED, {3'd0, led});
        captureDisplay("v13");

        // Sweep 0..15, each step must flip exactly one LED
        prevLed = led;
        for (int v = 0; v < 16; v++) begin
            applyStimulus(4'(v), 0);
            waitCycles(8);
            popCheck($sformatf("sweep%0d_led", v), KIND_LED, {3'd0, led});
            if (v > 0)
                checkOutput($sformatf("sweep%0d_onebit", v), 16'($countones(prevLed ^ led)), 16'd1);
            prevLed = led;
        end

        // One-cycle glitch to 9 that never lines up with a sample tick
        applyStimulus(4'd0, 0);
        waitCycles(8);
        popCheck("glitch_settle_led", KIND_LED, {3'd0, led});
        alignPhase(3);
        for (int i = 0; i < 12; i++) pushExp(KIND_LED, 7'h0F);
        binCode = 4'd9;
        waitCycles(1);
        binCode = 4'd0;
        for (int i = 0; i < 12; i++) begin
            popCheck($sformatf("glitch_led%0d", i), KIND_LED, {3'd0, led});
            waitCycles(1);
        end

`ifdef GRAY_AUTO_COUNT_EN
        // Auto-count from 14: gray 8, 0, 1 on successive ticks
        applyStimulus(4'd14, 0);
        waitCycles(8);
        popCheck("auto_settle_led", KIND_LED, {3'd0, led});
        alignPhase(1);
        autoPi = 1'b1;
        pushExp(KIND_LED, 7'h07);
        pushExp(KIND_LED, 7'h0F);
        pushExp(KIND_LED, 7'h0E);
        for (int i = 0; i < 3; i++) begin
            waitCycles(4);
            popCheck($sformatf("auto_step%0d_led", i), KIND_LED, {3'd0, led});
        end
        waitCycles(2);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("auto_reset_led", {12'd0, led}, 16'hF);
        checkOutput("auto_reset_anode", {14'd0, anode}, 16'h3);
        checkOutput("auto_reset_cathode", {9'd0, cathode}, 16'h7F);
        rst    = 1'b0;
        autoPi = 1'b0;
        waitCycles(2);
`endif

        checkOutput("scoreboard_drained", 16'(expQ.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
